// File: rtl/scroll_scheduler.sv
// Scrolling background sequencer: animation tick divider, score-driven step
// ramp, fixed-point scroll position (hundredths of a pixel) and run/pause/stop
// sequencing. The renderer only reads back_x / back_skip_x.
//
// state | meaning
// IDLE  | waiting for start, nothing moves
// RUN   | scrolling, step ramps toward the score target
// PAUSE | frozen; divider, position and step hold
// STOP  | game over, step decays by RAMP per tick until zero
module scroll_scheduler #(
  parameter int TICK_DIV    = 833333,
  parameter int MIN_STEP    = 100,
  parameter int PER_SCORE   = 30,
  parameter int MAX_STEP    = 1000,
  parameter int RAMP        = 10,
  parameter int SCR_W       = 640,
  parameter int SKIP_MARGIN = 5
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic [9:0] score,
  output logic       anim_tick,
  output logic [9:0] scroll_step,
  output logic [9:0] back_x,
  output logic [9:0] back_skip_x,
  output logic       wrapped,
  output logic [1:0] state
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [16:0] POS_MAX  = 17'(SCR_W * 100);
  localparam logic [9:0]  MIN_V    = 10'(MIN_STEP);
  localparam logic [9:0]  RAMP_V   = 10'(RAMP);
  localparam logic [9:0]  SCR_V    = 10'(SCR_W);
  localparam logic [9:0]  MARGIN_V = 10'(SKIP_MARGIN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       step_q, step_d;
  logic [16:0]      pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [19:0] target_raw;
  logic [9:0]  target;
  logic [10:0] step_up;
  logic [9:0]  step_dn;
  logic [9:0]  ramp_step;
  logic [9:0]  skip_gap;
  logic        counting;

  // Score-dependent target step, saturated; 20 bits so score=1023 cannot overflow.
  always_comb begin
    target_raw = 20'(MIN_STEP) + 20'(PER_SCORE) * {10'd0, score};
    target     = (target_raw > 20'(MAX_STEP)) ? 10'(MAX_STEP) : target_raw[9:0];
  end

  // Step candidates: ramp toward target in RUN, decay toward zero in STOP.
  always_comb begin
    step_up = {1'b0, step_q} + {1'b0, RAMP_V};
    step_dn = (step_q > RAMP_V) ? (step_q - RAMP_V) : 10'd0;
    if (target > step_q)
      ramp_step = (step_up > {1'b0, target}) ? target : step_up[9:0];
    else if (target < step_q)
      ramp_step = (step_dn < target) ? target : step_dn;
    else
      ramp_step = step_q;
  end

  // Next-state, divider, position and step; reload on entry to RUN wins over a tick.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    step_d   = step_q;
    pos_d    = pos_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    counting = (state_q == RUN) || ((state_q == STOP) && (step_q != 10'd0));

    if (counting) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
        if (pos_q < {7'd0, step_q}) begin
          pos_d  = POS_MAX;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - {7'd0, step_q};
        end
        step_d = (state_q == RUN) ? ramp_step : step_dn;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          div_d   = '0;
          step_d  = MIN_V;
          pos_d   = POS_MAX;
        end
      end
      RUN: begin
        if (game_over)  state_d = STOP;
        else if (pause) state_d = PAUSE;
      end
      PAUSE: begin
        if (game_over)   state_d = STOP;
        else if (!pause) state_d = RUN;
      end
      STOP: begin
        if (start && !game_over) begin
          state_d = RUN;
          div_d   = '0;
          step_d  = MIN_V;
          pos_d   = POS_MAX;
          tick_d  = 1'b0;
          wrap_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      div_q   <= '0;
      step_q  <= 10'd0;
      pos_q   <= POS_MAX;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
      pos_q   <= pos_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // Renderer-facing positions, combinational from pos.
  always_comb begin
    back_x      = 10'(pos_q / 17'd100);
    skip_gap    = SCR_V - back_x;
    back_skip_x = (skip_gap <= MARGIN_V) ? 10'd0 : (skip_gap - MARGIN_V);
  end

  assign anim_tick   = tick_q;
  assign wrapped     = wrap_q;
  assign scroll_step = step_q;
  assign state       = state_q;

endmodule
